// File: rtl/evt_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : evt_pulse_gen
// Description : Programmable event-burst generator. On an accepted command it
//               emits N single-cycle pulses spaced P cycles apart, then
//               strobes done_out. Command inputs are latched at acceptance.
//               Optional feature macro: EVT_PULSE_GEN_FREERUN_EN
//               (count_in == 0 selects endless pulsing until abort_in, and
//               sent_out wraps modulo MAX_COUNT).
// Revision    : 1.0 - initial release
// ============================================================================
module evt_pulse_gen #(
  parameter int MAX_COUNT  = 256,
  parameter int MAX_PERIOD = 256
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          start_in,
  input  logic [$clog2(MAX_COUNT)-1:0]  count_in,
  input  logic [$clog2(MAX_PERIOD)-1:0] period_in,
  input  logic                          abort_in,
  output logic                          ready_out,
  output logic                          busy_out,
  output logic                          evt_out,
  output logic                          done_out,
  output logic [$clog2(MAX_COUNT)-1:0]  sent_out
);

  localparam int CW = $clog2(MAX_COUNT);
  localparam int PW = $clog2(MAX_PERIOD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [CW-1:0] sent_q,  sent_d;
  logic [PW-1:0] per_q,   per_d;
  logic [PW-1:0] wait_q,  wait_d;

  // One extra bit keeps sent_q+1 from aliasing onto cnt_q when it overflows;
  // a zero cnt_q can therefore never look like the last pulse, which is what
  // lets the free-run build share this comparison unchanged.
  logic [CW:0]   sent_plus1;
  logic          last_pulse;
  logic [CW-1:0] sent_inc;

  assign sent_plus1 = {1'b0, sent_q} + {{CW{1'b0}}, 1'b1};
  assign last_pulse = (sent_plus1 == {1'b0, cnt_q});

`ifdef EVT_PULSE_GEN_FREERUN_EN
  // Explicit wrap so a non-power-of-two MAX_COUNT still wraps at MAX_COUNT-1.
  assign sent_inc = (sent_q == CW'(MAX_COUNT - 1)) ? '0 : sent_plus1[CW-1:0];
`else
  assign sent_inc = sent_plus1[CW-1:0];
`endif

  // Next-state and datapath decisions for the burst sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    wait_d  = wait_q;
    sent_d  = sent_q;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          cnt_d  = count_in;
          per_d  = (period_in == '0) ? PW'(1) : period_in;
          sent_d = '0;
`ifdef EVT_PULSE_GEN_FREERUN_EN
          // A zero count starts a free-running burst rather than completing.
          state_d = PULSE;
`else
          state_d = (count_in != '0) ? PULSE : DONE;
`endif
        end
      end
      PULSE: begin
        sent_d = sent_inc;
        if (abort_in) begin
          state_d = DONE;
        end else if (last_pulse) begin
          state_d = DONE;
        end else if (per_q == PW'(1)) begin
          state_d = PULSE;
        end else begin
          // The pulse cycle and the final zero-count cycle both consume one
          // slot of the period, hence the load of P-2.
          state_d = WAIT;
          wait_d  = per_q - PW'(2);
        end
      end
      WAIT: begin
        if (abort_in) begin
          state_d = DONE;
        end else if (wait_q == '0) begin
          state_d = PULSE;
        end else begin
          wait_d = wait_q - PW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      wait_q  <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      wait_q  <= wait_d;
      sent_q  <= sent_d;
    end
  end

  // Moore outputs decoded straight from the state register.
  assign ready_out = (state_q == IDLE);
  assign busy_out  = (state_q == PULSE) || (state_q == WAIT);
  assign evt_out   = (state_q == PULSE);
  assign done_out  = (state_q == DONE);
  assign sent_out  = sent_q;

endmodule
`default_nettype wire

// File: tb/tb_evt_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_evt_pulse_gen
// Description : Self-checking bench for evt_pulse_gen. A timeline model
//               derives every output from the accepted command's start cycle,
//               count, period and abort cycle using plain arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_evt_pulse_gen;

  localparam int     MC    = 16;
  localparam int     MP    = 16;
  localparam int     CW    = $clog2(MC);
  localparam int     PW    = $clog2(MP);
  localparam longint NEVER = 64'h3fff_ffff_ffff_ffff;

  logic          clk_in    = 1'b0;
  logic          rst_n_in  = 1'b1;
  logic          start_in  = 1'b0;
  logic          abort_in  = 1'b0;
  logic [CW-1:0] count_in  = '0;
  logic [PW-1:0] period_in = '0;
  logic          ready_out, busy_out, evt_out, done_out;
  logic [CW-1:0] sent_out;

  evt_pulse_gen #(.MAX_COUNT(MC), .MAX_PERIOD(MP)) dut (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .start_in  (start_in),
    .count_in  (count_in),
    .period_in (period_in),
    .abort_in  (abort_in),
    .ready_out (ready_out),
    .busy_out  (busy_out),
    .evt_out   (evt_out),
    .done_out  (done_out),
    .sent_out  (sent_out)
  );

  always #5 clk_in = ~clk_in;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;

  // Timeline model: one accepted burst described by its start cycle, period
  // and the cycle on which done_out is due.
  bit     m_have = 1'b0;
  longint m_T    = 0;
  longint m_P    = 1;
  longint m_done = 0;
  int     m_prev = 0;

  bit obs_done;
  int obs_sent;

  typedef struct {
    int n;
    int p;
    int ab_off;
    int exp_sent;
    int exp_done;
  } vec_t;

  vec_t vecs[$];

  function automatic void chk(input string name, input longint got, input longint want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endfunction

  function automatic void model_out(input longint c, output bit r, output bit b,
                                    output bit e, output bit d, output int s);
    longint lim, cnt;
    if (!m_have || c <= m_T) begin
      r = 1'b1; b = 1'b0; e = 1'b0; d = 1'b0; s = m_prev;
      return;
    end
    b   = (c < m_done);
    e   = b && (((c - m_T - 1) % m_P) == 0);
    d   = (c == m_done);
    r   = (c > m_done);
    lim = (c < m_done) ? c : m_done;
    cnt = (lim <= m_T + 1) ? 0 : (lim - m_T - 2) / m_P + 1;
    s   = int'(cnt % MC);
  endfunction

  function automatic void model_update(input longint c, input bit st, input int n,
                                       input int p, input bit ab);
    bit r, b, e, d;
    int s;
    model_out(c, r, b, e, d, s);
    if (st && r) begin
      m_prev = s;
      m_T    = c;
      m_P    = (p == 0) ? 1 : p;
      if (n == 0) begin
`ifdef EVT_PULSE_GEN_FREERUN_EN
        m_done = NEVER;
`else
        m_done = c + 1;
`endif
      end else begin
        m_done = c + 1 + (n - 1) * m_P + 1;
      end
      m_have = 1'b1;
    end else if (ab && b) begin
      m_done = c + 1;
    end
  endfunction

  task automatic tick(input bit st, input int n, input int p, input bit ab);
    bit r, b, e, d;
    int s;
    @(posedge clk_in);
    #1;
    cyc++;
    start_in  = st;
    count_in  = CW'(n);
    period_in = PW'(p);
    abort_in  = ab;
    model_out(cyc, r, b, e, d, s);
    @(negedge clk_in);
    n_checks++;
    if ({ready_out, busy_out, evt_out, done_out} != {r, b, e, d} || sent_out != CW'(s)) begin
      n_fail++;
      $display("FAIL outputs cycle %0d: got rdy/bsy/evt/done=%b%b%b%b sent=%0d, expected %b%b%b%b sent=%0d",
               cyc, ready_out, busy_out, evt_out, done_out, sent_out, r, b, e, d, s);
    end
    obs_done = done_out;
    obs_sent = int'(sent_out);
    model_update(cyc, st, n, p, ab);
  endtask

  task automatic do_reset(input int ncyc);
    @(posedge clk_in);
    #1;
    cyc++;
    rst_n_in = 1'b0;
    start_in = 1'b0;
    abort_in = 1'b0;
    #1;
    chk("reset_outputs", longint'({ready_out, busy_out, evt_out, done_out, sent_out}),
        longint'({1'b1, 1'b0, 1'b0, 1'b0, CW'(0)}));
    m_have = 1'b0;
    m_prev = 0;
    repeat (ncyc - 1) begin
      @(posedge clk_in);
      #1;
      cyc++;
    end
    @(posedge clk_in);
    #1;
    cyc++;
    rst_n_in = 1'b1;
  endtask

  // Runs one command from idle and measures completion against table values.
  task automatic run_vec(input vec_t v, input int idx, input bit hold_start);
    int done_off;
    done_off = -1;
    tick(1'b1, v.n, v.p, 1'b0);
    for (int k = 1; k <= 400; k++) begin
      tick(hold_start && (k <= 10), 7, 2, (k == v.ab_off));
      if (obs_done) begin
        done_off = k;
        break;
      end
    end
    chk($sformatf("vec%0d_done_delay", idx), done_off, v.exp_done);
    tick(1'b0, 0, 0, 1'b0);
    chk($sformatf("vec%0d_sent", idx), obs_sent, v.exp_sent);
    tick(1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //                n   p  ab sent done
    vecs.push_back('{ 3,  4, 0, 3, 10});
    vecs.push_back('{ 2,  0, 0, 2,  3});
    vecs.push_back('{ 5, 10, 3, 1,  4});
    vecs.push_back('{ 1,  7, 0, 1,  2});
    vecs.push_back('{ 4,  1, 0, 4,  5});
    vecs.push_back('{ 4,  2, 0, 4,  8});
    vecs.push_back('{15, 15, 0, 15, 212});
    vecs.push_back('{ 6,  3, 1, 1,  2});
    vecs.push_back('{ 6,  3, 5, 2,  6});
    vecs.push_back('{ 3,  2, 5, 3,  6});
`ifndef EVT_PULSE_GEN_FREERUN_EN
    vecs.push_back('{ 0,  5, 0, 0,  1});
`endif

    do_reset(3);
    tick(1'b0, 0, 0, 1'b0);
    tick(1'b0, 0, 0, 1'b0);

    foreach (vecs[i]) run_vec(vecs[i], i, 1'b0);

    // Start held high through the burst must not restart it.
    run_vec('{3, 4, 0, 3, 10}, 100, 1'b1);

    // Abort while idle is ignored; start with abort together is accepted.
    repeat (3) tick(1'b0, 0, 0, 1'b1);
    chk("idle_abort_ready", longint'(ready_out), 1);
    tick(1'b1, 2, 3, 1'b1);
    tick(1'b0, 0, 0, 1'b0);
    chk("start_abort_busy", longint'(busy_out), 1);
    repeat (6) tick(1'b0, 0, 0, 1'b0);

    // Reset in the middle of a burst: no further pulse, no done.
    tick(1'b1, 3, 4, 1'b0);
    repeat (5) tick(1'b0, 0, 0, 1'b0);
    do_reset(1);
    for (int k = 0; k < 15; k++) begin
      tick(1'b0, 0, 0, 1'b0);
      if (obs_done) chk("no_done_after_reset", 1, 0);
    end
    chk("sent_after_reset", obs_sent, 0);

`ifdef EVT_PULSE_GEN_FREERUN_EN
    // Free-run: count of zero pulses every cycle, sent_out wraps.
    tick(1'b1, 0, 1, 1'b0);
    repeat (20) tick(1'b0, 0, 0, 1'b0);
    chk("freerun_sent_wrap", obs_sent, 3);
    tick(1'b0, 0, 0, 1'b1);
    tick(1'b0, 0, 0, 1'b0);
    chk("freerun_done", longint'(obs_done), 1);
    repeat (3) tick(1'b0, 0, 0, 1'b0);
`endif

    // Random traffic against the timeline model.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(499, 0) == 0) begin
        do_reset(2);
      end else begin
        tick(($urandom_range(4, 0) == 0), int'($urandom_range(MC - 1, 0)),
             int'($urandom_range(MP - 1, 0)), ($urandom_range(29, 0) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
